// File: rtl/pe_feeder_if.sv
// rtl/pe_feeder_if.sv - job, operand-stream, PE and result signals of the PE feeder
interface pe_feeder_if #(
   parameter int DATA_W = 32,
   parameter int K_W    = 8
);
   logic              start;
   logic [K_W-1:0]    k_len;
   logic              a_valid;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic [DATA_W-1:0] b_data;
   logic              ab_ready;
   logic              pe_clr;
   logic              pe_load;
   logic [DATA_W-1:0] pe_row;
   logic [DATA_W-1:0] pe_col;
   logic              pe_done;
   logic [64:0]       pe_result;
   logic              res_valid;
   logic [64:0]       res_data;
   logic              res_ready;
   logic              busy;
   logic              err;

   // feeder side
   modport slave (
      input  start, k_len, a_valid, a_data, b_valid, b_data,
             pe_done, pe_result, res_ready,
      output ab_ready, pe_clr, pe_load, pe_row, pe_col,
             res_valid, res_data, busy, err
   );

   // job issuer / stream source / PE side
   modport master (
      output start, k_len, a_valid, a_data, b_valid, b_data,
             pe_done, pe_result, res_ready,
      input  ab_ready, pe_clr, pe_load, pe_row, pe_col,
             res_valid, res_data, busy, err
   );
endinterface

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - sequences k_len operand pairs into a MAC PE and returns its result
module pe_feeder #(
   parameter int DATA_W  = 32,
   parameter int K_W     = 8,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   pe_feeder_if.slave  bus
);
   // Counter wide enough to hold TIMEOUT+1 so the compare never sees a wrap.
   localparam int TMO_W = $clog2(TIMEOUT + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_FETCH, S_LOAD, S_WAIT, S_DONE
   } state_t;

   state_t            r_state;
   logic [K_W-1:0]    r_k_len;
   logic [K_W-1:0]    r_step;
   logic [TMO_W-1:0]  r_tmo;
   logic              r_ab_ready;
   logic              r_pe_clr;
   logic              r_pe_load;
   logic [DATA_W-1:0] r_pe_row;
   logic [DATA_W-1:0] r_pe_col;
   logic              r_res_valid;
   logic [64:0]       r_res_data;
   logic              r_busy;
   logic              r_err;

   logic              w_xfer;
   logic [K_W:0]      w_step_nxt;
   logic [TMO_W-1:0]  w_tmo_nxt;
   logic              w_last_step;
   logic              w_tmo_hit;

   // Step count is compared one bit wider so k_len = 2^K_W-1 terminates cleanly.
   assign w_xfer      = bus.a_valid && bus.b_valid && r_ab_ready;
   assign w_step_nxt  = {1'b0, r_step} + 1'b1;
   assign w_last_step = (w_step_nxt == {1'b0, r_k_len});
   // The timeout counter starts in LOAD, so TIMEOUT counts cycles from pe_load.
   assign w_tmo_nxt   = r_tmo + 1'b1;
   assign w_tmo_hit   = (w_tmo_nxt >= TMO_W'(TIMEOUT));

   // Job sequencer: every output is a register updated on the state transition.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_k_len     <= '0;
         r_step      <= '0;
         r_tmo       <= '0;
         r_ab_ready  <= 1'b0;
         r_pe_clr    <= 1'b0;
         r_pe_load   <= 1'b0;
         r_pe_row    <= '0;
         r_pe_col    <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_busy <= 1'b1;
                  r_err  <= 1'b0;
                  r_step <= '0;
                  if (bus.k_len != '0) begin
                     r_k_len  <= bus.k_len;
                     r_pe_clr <= 1'b1;
                     r_state  <= S_CLR;
                  end else begin
                     // Empty dot product: answer zero without touching the PE.
                     r_res_data  <= '0;
                     r_res_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_CLR: begin
               r_pe_clr   <= 1'b0;
               r_ab_ready <= 1'b1;
               r_state    <= S_FETCH;
            end
            S_FETCH: begin
               if (w_xfer) begin
                  r_pe_row   <= bus.a_data;
                  r_pe_col   <= bus.b_data;
                  r_ab_ready <= 1'b0;
                  r_pe_load  <= 1'b1;
                  r_tmo      <= '0;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_pe_load <= 1'b0;
               r_tmo     <= w_tmo_nxt;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.pe_done) begin
                  r_step <= w_step_nxt[K_W-1:0];
                  if (w_last_step) begin
                     r_res_data  <= bus.pe_result;
                     r_res_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_ab_ready <= 1'b1;
                     r_state    <= S_FETCH;
                  end
               end else if (w_tmo_hit) begin
                  // Hand back whatever the PE holds so far, flagged as failed.
                  r_err       <= 1'b1;
                  r_res_data  <= bus.pe_result;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_tmo <= w_tmo_nxt;
               end
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ab_ready  = r_ab_ready;
   assign bus.pe_clr    = r_pe_clr;
   assign bus.pe_load   = r_pe_load;
   assign bus.pe_row    = r_pe_row;
   assign bus.pe_col    = r_pe_col;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.busy      = r_busy;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - randomized bench for pe_feeder with a dot-product reference model
module tb_pe_feeder;
   localparam int DW  = 32;
   localparam int KW  = 8;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pe_feeder_if #(.DATA_W(DW), .K_W(KW)) bus ();

   pe_feeder #(.DATA_W(DW), .K_W(KW), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [DW-1:0] a_q[$];
   logic [DW-1:0] b_q[$];
   logic [64:0] acc = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.k_len     = '0;
      bus.a_valid   = 1'b0;
      bus.a_data    = '0;
      bus.b_valid   = 1'b0;
      bus.b_data    = '0;
      bus.pe_done   = 1'b0;
      bus.pe_result = '0;
      bus.res_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_err"}, bus.err, 0);
      check({tag, "_clr"}, bus.pe_clr, 0);
      check({tag, "_load"}, bus.pe_load, 0);
      check({tag, "_abrdy"}, bus.ab_ready, 0);
      check({tag, "_rv"}, bus.res_valid, 0);
      check({tag, "_row"}, bus.pe_row, 0);
      check({tag, "_col"}, bus.pe_col, 0);
      check({tag, "_rdata"}, bus.res_data, 0);
   endtask

   task automatic fill_random(input int k);
      a_q.delete();
      b_q.delete();
      for (int i = 0; i < k; i++) begin
         a_q.push_back($urandom);
         b_q.push_back($urandom);
      end
   endtask

   // One job: drives start, both operand streams, a behavioural PE and the result
   // handshake. lat = PE cycles from load to done, nodone = PE never answers,
   // hold = cycles res_ready stays low, abort_at = load index to reset in WAIT,
   // b_lag = extra delay of b_valid behind a_valid (negative = random).
   task automatic run_job(input int k, input int lat, input bit nodone, input int hold,
                          input int abort_at, input int b_lag);
      logic [64:0]   exp_res;
      logic [64:0]   first_data;
      logic [64:0]   prod;
      logic [DW-1:0] held_row, held_col;
      bit            exp_err, pe_busy, seen_rv, xfer_prev, ab_hold_prev, accepted, aborted;
      int            exp_loads, p, a_wait, b_wait, n_clr, n_load, pe_cnt;
      int            rv_cyc, start_cyc, load_cyc;

      exp_res = '0;
      prod = '0;
      first_data = '0;
      held_row = '0;
      held_col = '0;
      if (nodone) begin
         exp_err   = 1'b1;
         exp_loads = (k > 0) ? 1 : 0;
      end else begin
         exp_err   = 1'b0;
         exp_loads = k;
         for (int i = 0; i < k; i++) exp_res += 65'(a_q[i]) * 65'(b_q[i]);
      end
      pe_busy = 0; seen_rv = 0; xfer_prev = 0; ab_hold_prev = 0; accepted = 0; aborted = 0;
      p = 0; n_clr = 0; n_load = 0; pe_cnt = 0; rv_cyc = 0; start_cyc = 0; load_cyc = 0;
      a_wait = $urandom_range(0, 2);
      b_wait = a_wait + ((b_lag >= 0) ? b_lag : $urandom_range(0, 3));

      for (int c = 0; c < 40000 && !accepted && !aborted; c++) begin
         @(negedge clk);
         cyc++;
         // observe this cycle's outputs
         check("ab_excl", bus.ab_ready & (bus.pe_load | bus.pe_clr | bus.res_valid), 0);
         if (xfer_prev) check("load_lat", bus.pe_load, 1);
         if (ab_hold_prev) check("ab_hold", bus.ab_ready, 1);
         if (c == 1) check("busy_go", bus.busy, 1);
         if (bus.pe_clr) begin
            n_clr++;
            acc = '0;
         end
         bus.pe_done = 1'b0;
         if (bus.pe_load) begin
            if (n_load < k) begin
               check("pe_row", bus.pe_row, a_q[n_load]);
               check("pe_col", bus.pe_col, b_q[n_load]);
               prod = 65'(a_q[n_load]) * 65'(b_q[n_load]);
            end
            n_load++;
            load_cyc = cyc;
            held_row = bus.pe_row;
            held_col = bus.pe_col;
            pe_busy  = 1;
            pe_cnt   = lat;
         end else if (pe_busy && !nodone) begin
            pe_cnt--;
            if (pe_cnt == 0) begin
               acc += prod;
               bus.pe_done = 1'b1;
               pe_busy = 0;
               check("row_hold", bus.pe_row, held_row);
               check("col_hold", bus.pe_col, held_col);
            end
         end else if (!pe_busy) begin
            bus.pe_done = ($urandom_range(0, 7) == 0);
         end
         bus.pe_result = acc;

         if (bus.res_valid) begin
            if (!seen_rv) begin
               seen_rv    = 1;
               rv_cyc     = cyc;
               first_data = bus.res_data;
               check("res_data", bus.res_data, exp_res);
               check("res_err", bus.err, exp_err);
               if (k == 0) check("k0_lat", cyc - start_cyc, 1);
               if (nodone && k > 0) check("tmo_lat", cyc - load_cyc, TMO);
            end else begin
               check("res_hold", bus.res_data, first_data);
            end
            check("busy_done", bus.busy, 1);
         end

         if (abort_at > 0 && n_load == abort_at && pe_busy && (cyc - load_cyc) == 2) begin
            rst = 1'b0;
            idle_inputs();
            @(negedge clk);
            cyc++;
            rst = 1'b1;
            check_reset_outputs("abort");
            check("abort_norv", seen_rv, 0);
            check("abort_clr", n_clr, 1);
            aborted = 1;
         end else begin
            // drive next inputs
            if (c == 0) begin
               bus.start = 1'b1;
               bus.k_len = KW'(k);
               start_cyc = cyc;
            end else begin
               bus.start = bus.busy && ($urandom_range(0, 2) == 0);
               bus.k_len = KW'($urandom_range(0, 255));
            end
            xfer_prev = 0;
            if (p < k) begin
               bus.a_valid = (a_wait == 0);
               bus.b_valid = (b_wait == 0);
               bus.a_data  = bus.a_valid ? a_q[p] : DW'($urandom);
               bus.b_data  = bus.b_valid ? b_q[p] : DW'($urandom);
               if (a_wait > 0) a_wait--;
               if (b_wait > 0) b_wait--;
               if (bus.ab_ready && bus.a_valid && bus.b_valid) begin
                  xfer_prev = 1;
                  p++;
                  a_wait = $urandom_range(0, 2);
                  b_wait = a_wait + ((b_lag >= 0) ? b_lag : $urandom_range(0, 3));
               end
            end else begin
               bus.a_valid = 1'b0;
               bus.b_valid = 1'b0;
            end
            ab_hold_prev = bus.ab_ready && !xfer_prev;
            bus.res_ready = seen_rv && ((cyc - rv_cyc) >= hold);
            if (bus.res_ready && bus.res_valid) accepted = 1;
         end
      end

      if (!accepted && !aborted) check("job_end", 0, 1);
      if (accepted) begin
         @(negedge clk);
         cyc++;
         idle_inputs();
         bus.pe_result = acc;
         check("busy_idle", bus.busy, 0);
         check("rv_idle", bus.res_valid, 0);
         check("n_clr", n_clr, (k > 0) ? 1 : 0);
         check("n_load", n_load, exp_loads);
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // three fixed pairs, PE answers 4 cycles after load
      a_q = {32'd2, 32'd4, 32'd6};
      b_q = {32'd3, 32'd5, 32'd7};
      run_job(3, 4, 0, 0, 0, -1);

      // empty job
      a_q.delete();
      b_q.delete();
      run_job(0, 1, 0, 0, 0, -1);

      // b stream lags a by 5 cycles
      fill_random(2);
      run_job(2, 3, 0, 0, 0, 5);

      // PE never answers
      fill_random(3);
      run_job(3, 1, 1, 0, 0, -1);

      // result held unaccepted for 10 cycles while start is pulsed
      fill_random(2);
      run_job(2, 2, 0, 10, 0, -1);

      // reset in WAIT of step 2, then a single (9,9) step
      fill_random(3);
      run_job(3, 4, 0, 0, 2, -1);
      a_q = {32'd9};
      b_q = {32'd9};
      run_job(1, 2, 0, 0, 0, -1);

      // random jobs
      for (int j = 0; j < 20; j++) begin
         int kk;
         kk = $urandom_range(0, 6);
         fill_random(kk);
         run_job(kk, $urandom_range(1, 5), 0, $urandom_range(0, 3), 0, -1);
      end

      // longest job the length field allows
      fill_random(255);
      run_job(255, 1, 0, 1, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1);
   end
endmodule
